packet_mux: RTL and testbench
=============================

PACKET_MUX -- requirements
Module: packet_mux

Interface
REQ-001 Parameter CHANNEL_COUNT, default 4: number of input channels.
REQ-002 Parameter WORD_SIZE, default 32: bits per word.
REQ-003 Parameter SEGMENT_SIZE, default 3: maximum number of input entries per output segment.
REQ-004 Parameter INPUT_WORDS, default 2: words per input entry; SHALL be an integer multiple of OUTPUT_WORDS.
REQ-005 Parameter OUTPUT_WORDS, default 1: words per output beat.
REQ-006 Parameter HEADER_TEMPLATE, default 32'h10000000: constant base value of every header word.
REQ-007 Parameters HEADER_COUNT_SHIFT, HEADER_CHANNEL_SHIFT and HEADER_END_SHIFT, defaults 0, 8 and 16: bit positions of the header fields.
REQ-008 clk  in  1  sole clock; all logic rising-edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 in_full  out  CHANNEL_COUNT  per-channel buffer full.
REQ-011 in_shift  in  CHANNEL_COUNT  per-channel write strobe.
REQ-012 in_end  in  CHANNEL_COUNT  entry being written is the last entry of a packet.
REQ-013 in_data  in  CHANNEL_COUNT*INPUT_WORDS*WORD_SIZE  per-channel entry; channel c occupies slice c.
REQ-014 out_pop  in  1  consume the current output beat.
REQ-015 out_nempty  out  1  out_data holds a valid beat.
REQ-016 out_data  out  OUTPUT_WORDS*WORD_SIZE  current output beat.

Function
REQ-017 Each channel SHALL have its own FIFO of 2*SEGMENT_SIZE entries, each storing {end, data}.
REQ-018 When in_shift[c]=1 and in_full[c]=0, the FIFO SHALL store the entry on that edge; in_shift while full SHALL be ignored with no state change.
REQ-019 in_full[c] SHALL be 1 exactly when FIFO c holds 2*SEGMENT_SIZE entries.
REQ-020 A channel SHALL be ready when it holds at least SEGMENT_SIZE entries, or when it holds any entry with end=1.
REQ-021 A segment SHALL consist of the head entries up to SEGMENT_SIZE entries, stopping after and including the first end entry; count N is 1..SEGMENT_SIZE.
REQ-022 A round-robin arbiter SHALL select among ready channels only when idle, starting the search at the channel after the last one served; after reset the first search starts at channel 0.
REQ-023 Each segment SHALL be emitted as one header beat followed by N*(INPUT_WORDS/OUTPUT_WORDS) data beats, contiguously; segments SHALL never interleave.
REQ-024 Header word = HEADER_TEMPLATE | N<<HEADER_COUNT_SHIFT | channel<<HEADER_CHANNEL_SHIFT | E<<HEADER_END_SHIFT.
REQ-025 In the header, E SHALL be 1 if the segment's last entry has end=1.
REQ-026 The header word SHALL be placed in the low WORD_SIZE bits of the header beat, with the upper bits zero.
REQ-027 Each entry SHALL be split into beats least-significant beat first; an entry SHALL be removed from its FIFO when its last beat is popped.
REQ-028 out_data/out_nempty SHALL be show-ahead: a beat is presented and held stable until out_pop=1 with out_nempty=1.
REQ-029 out_pop while out_nempty=0 SHALL be ignored.
REQ-030 The header beat SHALL be presented no later than 2 cycles after a channel becomes ready while the mux is idle.
REQ-031 With continuous out_pop, beats SHALL advance one per cycle, including across segment boundaries.
REQ-032 Writes to a channel currently being emitted SHALL be accepted concurrently and SHALL NOT alter the segment already in progress.
REQ-033 Simultaneous writes on all channels SHALL all be accepted when the corresponding in_full is 0.

Reset
REQ-034 While rst=1, all FIFOs SHALL be emptied, the emission in progress aborted, and the arbiter pointer set to channel 0.
REQ-035 While rst=1, out_nempty=0, in_full=0 and out_data=0; reset asserted mid-segment SHALL discard the remainder.

Verification
REQ-036 Defaults; ch2 writes data 2,3,4 with end=0, then 5 with end=1; pop continuously -> beats 0x10000203,2,0,3,0,4,0,0x10010201,5,0.
REQ-037 ch1 writes single entry 7 with end=1 -> beats 0x10010101,7,0.
REQ-038 ch0 and ch3 each write 3 non-end entries in the same cycles -> ch0 segment (header 0x10000003) fully precedes ch3 segment (header 0x10000303).
REQ-039 ch0 gets 6 writes with no pops -> in_full[0]=1 after 6th; 7th write dropped; after popping header+2 beats, in_full[0]=0.
REQ-040 Hold out_pop=0 for 10 cycles with a beat pending -> out_data stable and out_nempty=1 throughout.
REQ-041 rst asserted after header beat popped -> next cycle out_nempty=0 and in_full=0; no stale beats after release.

Source files
------------

// File: rtl/packet_mux.sv
`default_nettype none
// ============================================================================
//  Module      : packet_mux
//  Description : Gathers entries from per-channel FIFOs into segments and
//                emits each one as a header beat followed by its data beats,
//                choosing between ready channels in round-robin order.
//  Revision    : 1.0  initial release
// ============================================================================
module packet_mux #(
    parameter int                   CHANNEL_COUNT        = 4,
    parameter int                   WORD_SIZE            = 32,
    parameter int                   SEGMENT_SIZE         = 3,
    parameter int                   INPUT_WORDS          = 2,
    parameter int                   OUTPUT_WORDS         = 1,
    parameter logic [WORD_SIZE-1:0] HEADER_TEMPLATE      = 32'h1000_0000,
    parameter int                   HEADER_COUNT_SHIFT   = 0,
    parameter int                   HEADER_CHANNEL_SHIFT = 8,
    parameter int                   HEADER_END_SHIFT     = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    output logic [CHANNEL_COUNT-1:0]                      in_full,
    input  logic [CHANNEL_COUNT-1:0]                      in_shift,
    input  logic [CHANNEL_COUNT-1:0]                      in_end,
    input  logic [CHANNEL_COUNT*INPUT_WORDS*WORD_SIZE-1:0] in_data,
    input  logic                                          out_pop,
    output logic                                          out_nempty,
    output logic [OUTPUT_WORDS*WORD_SIZE-1:0]             out_data
);

    localparam int c_DEPTH  = 2 * SEGMENT_SIZE;
    localparam int c_BEATS  = INPUT_WORDS / OUTPUT_WORDS;
    localparam int c_ENT_W  = INPUT_WORDS * WORD_SIZE;
    localparam int c_BEAT_W = OUTPUT_WORDS * WORD_SIZE;
    localparam int c_PTR_W  = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(c_DEPTH + 1);
    localparam int c_CH_W   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int c_N_W    = $clog2(SEGMENT_SIZE + 1);
    localparam int c_BT_W   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // FIFO storage: bit c_ENT_W is the end-of-packet flag
    logic [c_ENT_W:0]         r_mem     [CHANNEL_COUNT][c_DEPTH];
    logic [c_PTR_W-1:0]       r_wr_ptr  [CHANNEL_COUNT];
    logic [c_PTR_W-1:0]       r_rd_ptr  [CHANNEL_COUNT];
    logic [c_CNT_W-1:0]       r_cnt     [CHANNEL_COUNT];
    logic [c_CNT_W-1:0]       r_end_cnt [CHANNEL_COUNT];

    state_t                   r_state, w_state_nxt;
    logic [c_CH_W-1:0]        r_chan;
    logic [c_CH_W-1:0]        r_rr;
    logic [c_N_W-1:0]         r_n;
    logic [c_N_W-1:0]         r_ent;
    logic                     r_e;
    logic [c_BT_W-1:0]        r_beat;

    logic [CHANNEL_COUNT-1:0] w_full, w_wr, w_rd, w_ready;
    logic [c_CNT_W-1:0]       w_v_cnt   [CHANNEL_COUNT];
    logic [c_CNT_W-1:0]       w_v_end   [CHANNEL_COUNT];
    logic [c_PTR_W-1:0]       w_v_head  [CHANNEL_COUNT];
    logic [c_ENT_W:0]         w_head_ent;
    logic                     w_entry_pop, w_seg_done, w_arb_en, w_load;
    logic                     w_grant_valid;
    logic [c_CH_W-1:0]        w_grant;
    logic [c_N_W-1:0]         w_seg_n;
    logic                     w_seg_e;
    logic [WORD_SIZE-1:0]     w_hdr;

    function automatic logic [c_PTR_W-1:0] ptr_add(input logic [c_PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= c_DEPTH) s = s - c_DEPTH;
        return c_PTR_W'(s);
    endfunction

    // Per-channel strobes and the head entry of the channel being emitted
    always_comb begin
        w_head_ent  = r_mem[r_chan][r_rd_ptr[r_chan]];
        w_entry_pop = (r_state == S_DATA) && out_pop && (r_beat == c_BT_W'(c_BEATS - 1));
        w_seg_done  = w_entry_pop && (r_ent == (r_n - c_N_W'(1)));
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            w_full[c] = (r_cnt[c] == c_CNT_W'(c_DEPTH));
            w_wr[c]   = in_shift[c] && !w_full[c];
            w_rd[c]   = w_entry_pop && (r_chan == c_CH_W'(c));
        end
    end

    // Arbitration view: the entry being popped this cycle is treated as gone so
    // the next segment can be chosen on the same edge with no idle bubble
    always_comb begin
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            w_v_cnt[c]  = r_cnt[c];
            w_v_end[c]  = r_end_cnt[c];
            w_v_head[c] = r_rd_ptr[c];
            if (w_rd[c]) begin
                w_v_cnt[c]  = r_cnt[c] - c_CNT_W'(1);
                w_v_end[c]  = r_end_cnt[c] - c_CNT_W'(w_head_ent[c_ENT_W]);
                w_v_head[c] = ptr_add(r_rd_ptr[c], 1);
            end
            w_ready[c] = (w_v_cnt[c] >= c_CNT_W'(SEGMENT_SIZE)) || (w_v_end[c] != '0);
        end
    end

    // Round-robin grant from r_rr, then segment length/end flag of the winner
    always_comb begin
        int  s;
        logic v_found;
        w_grant       = '0;
        w_grant_valid = 1'b0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            s = int'(r_rr) + i;
            if (s >= CHANNEL_COUNT) s = s - CHANNEL_COUNT;
            if (!w_grant_valid && w_ready[c_CH_W'(s)]) begin
                w_grant       = c_CH_W'(s);
                w_grant_valid = 1'b1;
            end
        end
        w_seg_n = c_N_W'(SEGMENT_SIZE);
        w_seg_e = 1'b0;
        v_found = 1'b0;
        for (int k = 0; k < SEGMENT_SIZE; k++) begin
            if (!v_found && r_mem[w_grant][ptr_add(w_v_head[w_grant], k)][c_ENT_W]) begin
                w_seg_n = c_N_W'(k + 1);
                w_seg_e = 1'b1;
                v_found = 1'b1;
            end
        end
    end

    // Next-state logic and output beat selection
    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = (r_state == S_IDLE) || w_seg_done;
        w_load      = w_arb_en && w_grant_valid;
        w_hdr       = HEADER_TEMPLATE
                    | (WORD_SIZE'(r_n)    << HEADER_COUNT_SHIFT)
                    | (WORD_SIZE'(r_chan) << HEADER_CHANNEL_SHIFT)
                    | (WORD_SIZE'(r_e)    << HEADER_END_SHIFT);
        out_nempty  = 1'b0;
        out_data    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                out_nempty               = 1'b1;
                out_data[WORD_SIZE-1:0]  = w_hdr;
                if (out_pop) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                out_nempty = 1'b1;
                out_data   = w_head_ent[int'(r_beat)*c_BEAT_W +: c_BEAT_W];
                if (w_seg_done) w_state_nxt = w_grant_valid ? S_HDR : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst) begin
            out_nempty = 1'b0;
            out_data   = '0;
        end
        in_full = rst ? '0 : w_full;
    end

    // Channel FIFOs: write on accepted strobe, pop when an entry's last beat leaves
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            if (rst) begin
                r_wr_ptr[c]  <= '0;
                r_rd_ptr[c]  <= '0;
                r_cnt[c]     <= '0;
                r_end_cnt[c] <= '0;
            end else begin
                if (w_wr[c]) begin
                    r_mem[c][r_wr_ptr[c]] <= {in_end[c], in_data[c*c_ENT_W +: c_ENT_W]};
                    r_wr_ptr[c]           <= ptr_add(r_wr_ptr[c], 1);
                end
                if (w_rd[c]) r_rd_ptr[c] <= ptr_add(r_rd_ptr[c], 1);
                r_cnt[c]     <= r_cnt[c] + c_CNT_W'(w_wr[c]) - c_CNT_W'(w_rd[c]);
                r_end_cnt[c] <= r_end_cnt[c] + c_CNT_W'(w_wr[c] & in_end[c])
                              - c_CNT_W'(w_rd[c] & w_head_ent[c_ENT_W]);
            end
        end
    end

    // Emission state: latched segment descriptor, beat/entry counters, RR pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_chan  <= '0;
            r_rr    <= '0;
            r_n     <= '0;
            r_e     <= 1'b0;
            r_ent   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_chan <= w_grant;
                r_n    <= w_seg_n;
                r_e    <= w_seg_e;
                r_rr   <= (w_grant == c_CH_W'(CHANNEL_COUNT - 1)) ? '0 : w_grant + c_CH_W'(1);
            end
            if (r_state == S_HDR && out_pop) begin
                r_beat <= '0;
                r_ent  <= '0;
            end else if (r_state == S_DATA && out_pop) begin
                if (w_entry_pop) begin
                    r_beat <= '0;
                    r_ent  <= r_ent + c_N_W'(1);
                end else begin
                    r_beat <= r_beat + c_BT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_mux
//  Description : Directed self-checking bench for packet_mux (default params).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_packet_mux;

    localparam int CH = 4;
    localparam int WS = 32;
    localparam int IW = 2;
    localparam int OW = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       in_full;
    logic [CH-1:0]       in_shift;
    logic [CH-1:0]       in_end;
    logic [CH*IW*WS-1:0] in_data;
    logic                out_pop;
    logic                out_nempty;
    logic [OW*WS-1:0]    out_data;

    int n_total = 0;
    int n_bad   = 0;

    packet_mux dut (
        .clk        (clk),
        .rst        (rst),
        .in_full    (in_full),
        .in_shift   (in_shift),
        .in_end     (in_end),
        .in_data    (in_data),
        .out_pop    (out_pop),
        .out_nempty (out_nempty),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input int ch, input logic [63:0] d, input logic e);
        in_shift[ch]          = 1'b1;
        in_end[ch]            = e;
        in_data[ch*IW*WS +: IW*WS] = d;
    endtask

    task automatic step();
        @(negedge clk);
        in_shift = '0;
        in_end   = '0;
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int n;
        n = 0;
        while (!out_nempty && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(out_nempty), 64'd1);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] e);
        check({tag, "_nempty"}, 64'(out_nempty), 64'd1);
        check(tag, 64'(out_data), 64'(e));
        out_pop = 1'b1;
        @(negedge clk);
        out_pop = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_shift = '0;
        in_end   = '0;
        in_data  = '0;
        out_pop  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_nempty", 64'(out_nempty), 64'd0);
        check("rst_full",   64'(in_full),    64'd0);
        check("rst_data",   64'(out_data),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_nempty", 64'(out_nempty), 64'd0);

        // ch2: 2,3,4 then 5 with end; continuous pop across both segments
        put(2, 64'd2, 1'b0); step();
        put(2, 64'd3, 1'b0); step();
        put(2, 64'd4, 1'b0); step();
        put(2, 64'd5, 1'b1); step();
        wait_ready("t1_wait", 4);
        pop_expect("t1_b0", 32'h1000_0203);
        pop_expect("t1_b1", 32'd2);
        pop_expect("t1_b2", 32'd0);
        pop_expect("t1_b3", 32'd3);
        pop_expect("t1_b4", 32'd0);
        pop_expect("t1_b5", 32'd4);
        pop_expect("t1_b6", 32'd0);
        pop_expect("t1_b7", 32'h1001_0201);
        pop_expect("t1_b8", 32'd5);
        pop_expect("t1_b9", 32'd0);
        check("t1_empty", 64'(out_nempty), 64'd0);

        // ch1 single end entry; header must appear within 2 cycles
        put(1, 64'd7, 1'b1); step();
        wait_ready("t2_latency", 2);
        pop_expect("t2_b0", 32'h1001_0101);
        pop_expect("t2_b1", 32'd7);
        pop_expect("t2_b2", 32'd0);

        // fresh pointer: ch0 and ch3 ready together, ch0 goes first
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(0, {32'hA0 + 32'(i), 32'h10 + 32'(i)}, 1'b0);
            put(3, {32'hC0 + 32'(i), 32'h30 + 32'(i)}, 1'b0);
            step();
        end
        wait_ready("t3_wait", 4);
        pop_expect("t3_h0", 32'h1000_0003);
        for (int i = 0; i < 3; i++) begin
            pop_expect($sformatf("t3_c0_lo%0d", i), 32'h10 + 32'(i));
            pop_expect($sformatf("t3_c0_hi%0d", i), 32'hA0 + 32'(i));
        end
        pop_expect("t3_h3", 32'h1000_0303);
        for (int i = 0; i < 3; i++) begin
            pop_expect($sformatf("t3_c3_lo%0d", i), 32'h30 + 32'(i));
            pop_expect($sformatf("t3_c3_hi%0d", i), 32'hC0 + 32'(i));
        end
        check("t3_empty", 64'(out_nempty), 64'd0);

        // stall: beat must hold for 10 cycles without pop
        put(1, {32'h77, 32'h55}, 1'b1); step();
        wait_ready("t4_wait", 4);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t4_hold_ne%0d", i), 64'(out_nempty), 64'd1);
            check($sformatf("t4_hold_d%0d", i), 64'(out_data), 64'h1001_0101);
            @(negedge clk);
        end
        pop_expect("t4_b0", 32'h1001_0101);
        pop_expect("t4_b1", 32'h55);
        pop_expect("t4_b2", 32'h77);

        // ch0 fill to full, 7th write dropped, full clears after first entry pops
        for (int i = 0; i < 6; i++) begin
            put(0, {32'hB0 + 32'(i), 32'h100 + 32'(i)}, 1'b0);
            step();
        end
        check("t5_full6", 64'(in_full[0]), 64'd1);
        put(0, {32'h999, 32'h999}, 1'b1); step();
        check("t5_full7", 64'(in_full[0]), 64'd1);
        pop_expect("t5_h0", 32'h1000_0003);
        pop_expect("t5_e0lo", 32'h100);
        pop_expect("t5_e0hi", 32'hB0);
        check("t5_notfull", 64'(in_full[0]), 64'd0);
        for (int i = 1; i < 3; i++) begin
            pop_expect($sformatf("t5_lo%0d", i), 32'h100 + 32'(i));
            pop_expect($sformatf("t5_hi%0d", i), 32'hB0 + 32'(i));
        end
        pop_expect("t5_h1", 32'h1000_0003);
        for (int i = 3; i < 6; i++) begin
            pop_expect($sformatf("t5_lo%0d", i), 32'h100 + 32'(i));
            pop_expect($sformatf("t5_hi%0d", i), 32'hB0 + 32'(i));
        end
        repeat (2) @(negedge clk);
        check("t5_dropped", 64'(out_nempty), 64'd0);

        // reset mid-segment discards everything
        for (int i = 0; i < 3; i++) begin
            put(2, {32'h0, 32'h20 + 32'(i)}, 1'b0);
            put(3, {32'h0, 32'h40 + 32'(i)}, 1'b0);
            step();
        end
        for (int i = 3; i < 6; i++) begin
            put(3, {32'h0, 32'h40 + 32'(i)}, 1'b0);
            step();
        end
        check("t6_full3", 64'(in_full[3]), 64'd1);
        wait_ready("t6_wait", 4);
        pop_expect("t6_h", 32'h1000_0203);
        pop_expect("t6_b1", 32'h20);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_nempty", 64'(out_nempty), 64'd0);
        check("t6_rst_full",   64'(in_full),    64'd0);
        check("t6_rst_data",   64'(out_data),   64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_nostale", 64'(out_nempty), 64'd0);
        check("t6_full_after", 64'(in_full), 64'd0);

        // normal operation after reset
        put(3, {32'h9, 32'h8}, 1'b1); step();
        wait_ready("t7_wait", 2);
        pop_expect("t7_b0", 32'h1001_0301);
        pop_expect("t7_b1", 32'h8);
        pop_expect("t7_b2", 32'h9);
        check("t7_empty", 64'(out_nempty), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
